// File: rtl/alu_issue.sv
// Multicycle issuer for RV32I ALU-class instructions: latches a request, decodes it into
// ALU operands/opcode, captures the ALU result and returns it with rd over a valid/ready response.
module alu_issue #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [31:0]           ir_i,
    input  logic [DATA_WIDTH-1:0] rs1_i,
    input  logic [DATA_WIDTH-1:0] rs2_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    output logic [DATA_WIDTH-1:0] alu_a_o,
    output logic [DATA_WIDTH-1:0] alu_b_o,
    output logic [3:0]            alu_op_o,
    input  logic [DATA_WIDTH-1:0] alu_y_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic [4:0]            rd_o,
    output logic                  illegal_o
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DECODE = 2'd1;
    localparam logic [1:0] S_EXEC   = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLTU = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;

    logic [1:0]            state_q, state_d;
    logic [31:0]           ir_q;
    logic [DATA_WIDTH-1:0] rs1_q, rs2_q, pc_q;
    logic [DATA_WIDTH-1:0] alu_a_q, alu_b_q, result_q;
    logic [3:0]            alu_op_q;
    logic [4:0]            rd_q;
    logic                  illegal_q;

    logic                  dec_legal;
    logic [DATA_WIDTH-1:0] dec_a, dec_b;
    logic [3:0]            dec_op;

    logic [6:0]            opcode, funct7;
    logic [2:0]            funct3;
    logic [DATA_WIDTH-1:0] imm_i, imm_u, shamt;

    assign opcode = ir_q[6:0];
    assign funct3 = ir_q[14:12];
    assign funct7 = ir_q[31:25];
    assign imm_i  = {{(DATA_WIDTH-12){ir_q[31]}}, ir_q[31:20]};
    assign imm_u  = {ir_q[31:12], 12'b0};
    assign shamt  = {{(DATA_WIDTH-5){1'b0}}, ir_q[24:20]};

    always_comb begin
        dec_legal = 1'b0;
        dec_a     = rs1_q;
        dec_b     = rs2_q;
        dec_op    = OP_ADD;
        case (opcode)
            7'b0110011: begin
                if (funct7 == 7'b0000000) begin
                    dec_legal = 1'b1;
                    case (funct3)
                        3'b000:  dec_op = OP_ADD;
                        3'b001:  dec_op = OP_SLL;
                        3'b010:  dec_op = OP_SLT;
                        3'b011:  dec_op = OP_SLTU;
                        3'b100:  dec_op = OP_XOR;
                        3'b101:  dec_op = OP_SRL;
                        3'b110:  dec_op = OP_OR;
                        default: dec_op = OP_AND;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    dec_legal = 1'b1;
                    dec_op    = OP_SUB;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
                    dec_legal = 1'b1;
                    dec_op    = OP_SRA;
                end
            end
            7'b0010011: begin
                dec_b = imm_i;
                case (funct3)
                    3'b000: begin dec_legal = 1'b1; dec_op = OP_ADD;  end
                    3'b010: begin dec_legal = 1'b1; dec_op = OP_SLT;  end
                    3'b011: begin dec_legal = 1'b1; dec_op = OP_SLTU; end
                    3'b100: begin dec_legal = 1'b1; dec_op = OP_XOR;  end
                    3'b110: begin dec_legal = 1'b1; dec_op = OP_OR;   end
                    3'b111: begin dec_legal = 1'b1; dec_op = OP_AND;  end
                    3'b001: begin
                        dec_b     = shamt;
                        dec_op    = OP_SLL;
                        dec_legal = (funct7 == 7'b0000000);
                    end
                    default: begin
                        // funct3 101: funct7 picks logical vs arithmetic right shift
                        dec_b     = shamt;
                        dec_op    = (funct7 == 7'b0100000) ? OP_SRA : OP_SRL;
                        dec_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                    end
                endcase
            end
            7'b0110111: begin
                dec_legal = 1'b1;
                dec_a     = '0;
                dec_b     = imm_u;
            end
            7'b0010111: begin
                dec_legal = 1'b1;
                dec_a     = pc_q;
                dec_b     = imm_u;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (req_valid_i) state_d = S_DECODE;
            S_DECODE: state_d = dec_legal ? S_EXEC : S_RESP;
            S_EXEC:   state_d = S_RESP;
            default:  if (rsp_ready_i) state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= S_IDLE;
            ir_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            pc_q      <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= OP_ADD;
            result_q  <= '0;
            rd_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && req_valid_i) begin
                ir_q  <= ir_i;
                rs1_q <= rs1_i;
                rs2_q <= rs2_i;
                pc_q  <= pc_i;
            end
            if (state_q == S_DECODE) begin
                rd_q <= ir_q[11:7];
                if (dec_legal) begin
                    alu_a_q  <= dec_a;
                    alu_b_q  <= dec_b;
                    alu_op_q <= dec_op;
                end else begin
                    illegal_q <= 1'b1;
                    result_q  <= '0;
                end
            end
            if (state_q == S_EXEC) begin
                result_q  <= alu_y_i;
                illegal_q <= 1'b0;
            end
        end
    end

    assign req_ready_o = (state_q == S_IDLE);
    assign rsp_valid_o = (state_q == S_RESP);
    assign alu_a_o     = alu_a_q;
    assign alu_b_o     = alu_b_q;
    assign alu_op_o    = alu_op_q;
    assign result_o    = result_q;
    assign rd_o        = rd_q;
    assign illegal_o   = illegal_q;
endmodule

// File: tb/tb_alu_issue.sv
// Directed-vector bench for alu_issue with a behavioural ALU closing the loop on alu_y_i.
module tb_alu_issue;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready;
    logic [31:0] ir, rs1, rs2, pc;
    logic [31:0] alu_a, alu_b, alu_y, result;
    logic [3:0]  alu_op;
    logic        rsp_valid, rsp_ready;
    logic [4:0]  rd;
    logic        illegal;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] pc;
        logic        ill;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] res;
        logic [4:0]  rd;
    } vec_t;

    vec_t vecs[13];
    logic [31:0] prev_a, prev_b;
    logic [3:0]  prev_op;

    always #5 clk = ~clk;

    alu_issue #(.DATA_WIDTH(32)) dut (
        .clk_i(clk), .reset_ni(reset_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .ir_i(ir), .rs1_i(rs1), .rs2_i(rs2), .pc_i(pc),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op), .alu_y_i(alu_y),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .result_o(result), .rd_o(rd), .illegal_o(illegal)
    );

    always_comb begin
        alu_y = 32'h0;
        case (alu_op)
            4'd0: alu_y = alu_a + alu_b;
            4'd1: alu_y = alu_a - alu_b;
            4'd2: alu_y = alu_a & alu_b;
            4'd3: alu_y = alu_a | alu_b;
            4'd4: alu_y = alu_a ^ alu_b;
            4'd5: alu_y = {31'b0, alu_a < alu_b};
            4'd6: alu_y = {31'b0, $signed(alu_a) < $signed(alu_b)};
            4'd7: alu_y = alu_a << alu_b[4:0];
            4'd8: alu_y = alu_a >> alu_b[4:0];
            4'd9: alu_y = $signed(alu_a) >>> alu_b[4:0];
            default: alu_y = 32'h0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_wait", {31'b0, req_ready}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        wait_ready();
        ir = v.ir; rs1 = v.rs1; rs2 = v.rs2; pc = v.pc;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("decode_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("decode_req_ready", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        if (!v.ill) begin
            chk("alu_a", alu_a, v.a);
            chk("alu_b", alu_b, v.b);
            chk("alu_op", {28'b0, alu_op}, {28'b0, v.op});
            chk("exec_rsp_valid", {31'b0, rsp_valid}, 32'd0);
            @(negedge clk);
            prev_a = v.a; prev_b = v.b; prev_op = v.op;
        end else begin
            chk("ill_alu_a_kept", alu_a, prev_a);
            chk("ill_alu_b_kept", alu_b, prev_b);
            chk("ill_alu_op_kept", {28'b0, alu_op}, {28'b0, prev_op});
        end
        chk("rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("result", result, v.res);
        chk("rd", {27'b0, rd}, {27'b0, v.rd});
        chk("illegal", {31'b0, illegal}, {31'b0, v.ill});
        @(negedge clk);
        chk("post_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("post_req_ready", {31'b0, req_ready}, 32'd1);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
        chk({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
        chk({tag, "_alu_op"}, {28'b0, alu_op}, 32'd0);
        chk({tag, "_alu_a"}, alu_a, 32'd0);
        chk({tag, "_result"}, result, 32'd0);
        chk({tag, "_rd"}, {27'b0, rd}, 32'd0);
        chk({tag, "_illegal"}, {31'b0, illegal}, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{32'h002081B3, 32'd5,        32'd7,    32'h0,   1'b0, 32'd5,        32'd7,        4'd0, 32'd12,       5'd3};
        vecs[1]  = '{32'h40435293, 32'h80000000, 32'h0,    32'h0,   1'b0, 32'h80000000, 32'd4,        4'd9, 32'hF8000000, 5'd5};
        vecs[2]  = '{32'h12345097, 32'h0,        32'h0,    32'h100, 1'b0, 32'h100,      32'h12345000, 4'd0, 32'h12345100, 5'd1};
        vecs[3]  = '{32'h00000073, 32'd1,        32'd2,    32'h0,   1'b1, 32'h0,        32'h0,        4'd0, 32'h0,        5'd0};
        vecs[4]  = '{32'h022081B3, 32'd3,        32'd4,    32'h0,   1'b1, 32'h0,        32'h0,        4'd0, 32'h0,        5'd3};
        vecs[5]  = '{32'h40C58533, 32'd3,        32'd10,   32'h0,   1'b0, 32'd3,        32'd10,       4'd1, 32'hFFFFFFF9, 5'd10};
        vecs[6]  = '{32'hFFF10093, 32'd5,        32'h0,    32'h0,   1'b0, 32'd5,        32'hFFFFFFFF, 4'd0, 32'd4,        5'd1};
        vecs[7]  = '{32'h0062A233, 32'hFFFFFFFF, 32'd1,    32'h0,   1'b0, 32'hFFFFFFFF, 32'd1,        4'd6, 32'd1,        5'd4};
        vecs[8]  = '{32'h0062B233, 32'hFFFFFFFF, 32'd1,    32'h0,   1'b0, 32'hFFFFFFFF, 32'd1,        4'd5, 32'd0,        5'd4};
        vecs[9]  = '{32'hABCDE3B7, 32'd9,        32'd9,    32'h40,  1'b0, 32'h0,        32'hABCDE000, 4'd0, 32'hABCDE000, 5'd7};
        vecs[10] = '{32'h40001013, 32'd1,        32'd1,    32'h0,   1'b1, 32'h0,        32'h0,        4'd0, 32'h0,        5'd0};
        vecs[11] = '{32'h00419133, 32'd1,        32'h25,   32'h0,   1'b0, 32'd1,        32'h25,       4'd7, 32'd32,       5'd2};
        vecs[12] = '{32'h0F04C493, 32'hFF,       32'h0,    32'h0,   1'b0, 32'hFF,       32'hF0,       4'd4, 32'h0F,       5'd9};

        reset_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
        ir = 32'h0; rs1 = 32'h0; rs2 = 32'h0; pc = 32'h0;
        prev_a = 32'h0; prev_b = 32'h0; prev_op = 4'd0;
        #1;
        chk_reset_state("por");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++) run_vec(vecs[i]);

        // Asynchronous reset mid-cycle with non-zero ALU state (last op was XOR)
        #2 reset_n = 1'b0;
        #1 chk_reset_state("async_rst");
        #1 reset_n = 1'b1;
        prev_a = 32'h0; prev_b = 32'h0; prev_op = 4'd0;
        @(negedge clk);

        // Backpressure: RESP holds, further requests ignored
        rsp_ready = 1'b0;
        wait_ready();
        ir = 32'h002081B3; rs1 = 32'd100; rs2 = 32'd23; pc = 32'h0;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("bp_result", result, 32'd123);
        for (int c = 0; c < 5; c++) begin
            ir = 32'h40C58533; rs1 = 32'd9 + c; rs2 = 32'd1; pc = 32'h80;
            req_valid = 1'b1;
            @(negedge clk);
            chk("bp_hold_valid", {31'b0, rsp_valid}, 32'd1);
            chk("bp_hold_result", result, 32'd123);
            chk("bp_hold_rd", {27'b0, rd}, 32'd3);
            chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
            chk("bp_alu_a", alu_a, 32'd100);
            chk("bp_alu_op", {28'b0, alu_op}, 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", {31'b0, rsp_valid}, 32'd0);
        chk("bp_release_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        chk("bp_no_latch_ready", {31'b0, req_ready}, 32'd1);
        prev_a = 32'd100; prev_b = 32'd23; prev_op = 4'd0;
        run_vec(vecs[3]);

        // Reset while in RESP
        rsp_ready = 1'b0;
        wait_ready();
        ir = 32'h40435293; rs1 = 32'h80000000; rs2 = 32'h0; pc = 32'h0;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("resp_rst_pre_valid", {31'b0, rsp_valid}, 32'd1);
        #2 reset_n = 1'b0;
        #1 chk_reset_state("resp_rst");
        #1 reset_n = 1'b1;
        rsp_ready = 1'b1;
        prev_a = 32'h0; prev_b = 32'h0; prev_op = 4'd0;
        @(negedge clk);
        chk("resp_rst_idle", {31'b0, rsp_valid}, 32'd0);
        run_vec(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/alu_issue.md
# alu_issue

Multicycle operand/opcode issuer that drives the ALU, the producing end of the ALU operation interface. It accepts one RV32I ALU-class instruction with its register operands over a valid/ready request, decodes it to an `ALU_Ops` code, and registers operands A/B into the combinational ALU. It then captures the ALU result and presents it with the destination register over a valid/ready response. It sits between the multicycle control FSM / register-file read stage and the ALU.

## Interface
- `DATA_WIDTH`, 32, datapath width; only 32 is supported.
- `clk_i`  in  1  clock; all state updates on rising edge.
- `reset_ni`  in  1  reset; asynchronous, active-low.
- `req_valid_i`  in  1  request valid.
- `req_ready_o`  out  1  request ready; high only in IDLE.
- `ir_i`  in  32  instruction word.
- `rs1_i`, `rs2_i`  in  DATA_WIDTH  register operands.
- `pc_i`  in  DATA_WIDTH  PC of the instruction, used by AUIPC.
- `alu_a_o`, `alu_b_o`  out  DATA_WIDTH  registered ALU operands.
- `alu_op_o`  out  4  registered `ALU_Ops` code.
- `alu_y_i`  in  DATA_WIDTH  ALU result, combinational from `alu_*_o`.
- `rsp_valid_o`  out  1  response valid.
- `rsp_ready_i`  in  1  response ready.
- `result_o`  out  DATA_WIDTH  captured result.
- `rd_o`  out  5  destination register, `ir[11:7]`.
- `illegal_o`  out  1  instruction not decodable to an ALU op.

## Operation
- **ALU_Ops encoding:** Add=0, Sub=1, And=2, Or=3, Xor=4, Sltu=5, Slt=6, Sll=7, Srl=8, Sra=9.
- **FSM states:** IDLE, DECODE, EXEC, RESP.
  - IDLE: on `req_valid_i`, latch `ir_i`, `rs1_i`, `rs2_i`, `pc_i`, then go to DECODE.
  - DECODE: if the instruction is legal, load `alu_a_o`, `alu_b_o`, `alu_op_o` and go to EXEC. If illegal, set `illegal_o`=1 and `result_o`=0, leave the ALU registers unchanged, and go to RESP.
  - EXEC: capture `alu_y_i` into `result_o`, set `illegal_o`=0, go to RESP.
  - RESP: `rsp_valid_o`=1; on `rsp_ready_i`, go to IDLE.
- **OP (0110011):** A=rs1, B=rs2.
  - funct7=0000000: funct3 000 Add, 001 Sll, 010 Slt, 011 Sltu, 100 Xor, 101 Srl, 110 Or, 111 And.
  - funct7=0100000: funct3 000 Sub, 101 Sra.
  - Any other funct7/funct3 combination is illegal.
- **OP-IMM (0010011):** A=rs1, B=sign-extended `ir[31:20]`.
  - funct3 000 Add, 010 Slt, 011 Sltu, 100 Xor, 110 Or, 111 And.
  - Shifts use B={27'b0, `ir[24:20]`}: 001 Sll requires `ir[31:25]`=0; 101 with `ir[31:25]`=0 is Srl, with 0100000 is Sra. Anything else is illegal.
- **LUI (0110111):** A=0, B={`ir[31:12]`, 12'b0}, Add.
- **AUIPC (0010111):** A=pc, B={`ir[31:12]`, 12'b0}, Add.
- All other opcodes are illegal.
- `rd_o` = `ir[11:7]` for legal and illegal requests; it is updated in DECODE.
- `result_o`, `rd_o` and `illegal_o` hold stable from RESP entry until the next DECODE/EXEC update.

## Timing
- **Reset values:** state IDLE, `req_ready_o`=1, `rsp_valid_o`=0, `result_o`=0, `rd_o`=0, `illegal_o`=0, `alu_a_o`=0, `alu_b_o`=0, `alu_op_o`=Add(0).
- **Legal latency:** accept edge E0, DECODE after E0, ALU inputs valid after E1, `rsp_valid_o`=1 after E2 (3 cycles).
- **Illegal latency:** `rsp_valid_o`=1 after E1 (2 cycles).
- **Response handshake:** completes on the edge where `rsp_valid_o` and `rsp_ready_i` are both high. If `rsp_ready_i` is already high when RESP is entered, RESP lasts exactly one cycle. `req_ready_o` rises the cycle after the handshake.
- **Throughput:** at most one request per 4 cycles (legal).
- **Requests outside IDLE:** `req_valid_i` is ignored and no input is latched.
- **Backpressure:** RESP holds indefinitely while `rsp_ready_i`=0.
- **Reset mid-operation:** asserting `reset_ni` in any state abandons the operation. All outputs go to their reset values immediately, without waiting for a clock edge.

## Test plan
- **Reset:** pulse `reset_ni` low mid-cycle → `req_ready_o`=1, `rsp_valid_o`=0, `alu_op_o`=0 with no clock edge required.
- **ADD:** `ir`=0x002081B3 (add x3,x1,x2), rs1=5, rs2=7, behavioural ALU model → `alu_op_o`=0, A=5, B=7; 3 cycles later `rsp_valid_o`=1, `result_o`=12, `rd_o`=3, `illegal_o`=0.
- **SRAI:** `ir`=0x40435293 (srai x5,x6,4), rs1=0x80000000 → `alu_op_o`=9, B=4, `result_o`=0xF8000000, `rd_o`=5.
- **AUIPC:** `ir`=0x12345097, `pc_i`=0x100 → A=0x100, B=0x12345000, `result_o`=0x12345100, `rd_o`=1.
- **Illegal, system opcode:** `ir`=0x00000073 → `rsp_valid_o`=1 two cycles after accept, `illegal_o`=1, `result_o`=0, ALU registers unchanged from the prior request.
- **Illegal, MUL:** `ir`=0x022081B3 → `illegal_o`=1, `result_o`=0.
- **Backpressure:** hold `rsp_ready_i`=0 for 5 cycles while pulsing `req_valid_i` → outputs stable, `req_ready_o`=0, nothing latched.
- **Reset during RESP:** assert `reset_ni` low while in RESP → `rsp_valid_o` falls immediately.
